// File: rtl/memory_cycle_if.sv
// rtl/memory_cycle_if.sv - M->W bus bundle between the pipeline, the MEM stage and write-back
interface memory_cycle_if;
  logic        RegWriteM;
  logic        MemtoRegM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [4:0]  WriteRegM;
  logic        StallM;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic [31:0] ReadDataW;
  logic [31:0] ALUOutW;
  logic [4:0]  WriteRegW;

  modport master (
    output RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM,
    input  StallM, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW
  );

  modport slave (
    input  RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM,
    output StallM, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW
  );
endinterface

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - MEM stage: word data memory, wait-state FSM and MEM/WB register
module memory_cycle #(
  parameter int ADDR_BITS   = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  memory_cycle_if.slave bus
);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            reg_write_q;
  logic            mem_to_reg_q;
  logic [31:0]     read_data_q;
  logic [31:0]     alu_out_q;
  logic [4:0]      write_reg_q;

  logic [31:0]          mem [0:(1<<ADDR_BITS)-1];
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          rdata;
  logic                 access;
  logic                 stall;

  assign idx    = bus.ALUOutM[ADDR_BITS+1:2];
  assign rdata  = mem[idx];
  assign access = bus.MemtoRegM | bus.MemWriteM;

  // Stall is gated by rst so a held access cannot raise it while in reset.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE:  stall = access && (MEM_LATENCY != 0);
        S_WAIT:  stall = (cnt_q != '0);
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      read_data_q  <= '0;
      alu_out_q    <= '0;
      write_reg_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (access && (MEM_LATENCY != 0)) begin
            state_q <= S_WAIT;
            cnt_q   <= CNT_INIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else             state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (stall) begin
        reg_write_q  <= 1'b0;
        mem_to_reg_q <= 1'b0;
        write_reg_q  <= '0;
      end else begin
        reg_write_q  <= bus.RegWriteM;
        mem_to_reg_q <= bus.MemtoRegM;
        write_reg_q  <= bus.WriteRegM;
        alu_out_q    <= bus.ALUOutM;
        read_data_q  <= rdata;
      end
    end
  end

  // Store commits only on the completing edge; load data above is pre-store.
  always_ff @(posedge clk) begin
    if (!rst && !stall && bus.MemWriteM) mem[idx] <= bus.WriteDataM;
  end

  assign bus.StallM    = stall;
  assign bus.RegWriteW = reg_write_q;
  assign bus.MemtoRegW = mem_to_reg_q;
  assign bus.ReadDataW = read_data_q;
  assign bus.ALUOutW   = alu_out_q;
  assign bus.WriteRegW = write_reg_q;
endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - directed checks of memory_cycle at latency 2 and latency 0
module tb_memory_cycle;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  memory_cycle_if bus_a ();
  memory_cycle_if bus_z ();

  memory_cycle #(.ADDR_BITS(8), .MEM_LATENCY(2)) u_dut (.clk(clk), .rst(rst), .bus(bus_a));
  memory_cycle #(.ADDR_BITS(8), .MEM_LATENCY(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus_z));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic rw, input logic m2r, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    bus_a.RegWriteM  = rw;
    bus_a.MemtoRegM  = m2r;
    bus_a.MemWriteM  = mw;
    bus_a.ALUOutM    = alu;
    bus_a.WriteDataM = wd;
    bus_a.WriteRegM  = wr;
  endtask

  task automatic drive_z(input logic rw, input logic m2r, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    bus_z.RegWriteM  = rw;
    bus_z.MemtoRegM  = m2r;
    bus_z.MemWriteM  = mw;
    bus_z.ALUOutM    = alu;
    bus_z.WriteDataM = wd;
    bus_z.WriteRegM  = wr;
  endtask

  // Presents a latency-2 access and walks the three edges it takes to complete.
  task automatic access_a(input string tag, input logic rw, input logic m2r, input logic mw,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    int stalls;
    stalls = 0;
    drive_a(rw, m2r, mw, alu, wd, wr);
    for (int k = 0; k < 3; k++) begin
      #1;
      if (bus_a.StallM) stalls++;
      check({tag, "_stall"}, {31'b0, bus_a.StallM}, {31'b0, (k < 2)});
      tick();
      if (k < 2)
        check({tag, "_bubble"}, {26'b0, bus_a.RegWriteW, bus_a.WriteRegW},
              32'h0);
    end
    check({tag, "_stall_cycles"}, stalls, 32'd2);
    drive_a(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    drive_a(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    drive_z(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    tick();
    rst = 1'b0;
    check("reset_regwrite", {31'b0, bus_a.RegWriteW}, 32'h0);
    check("reset_aluout", bus_a.ALUOutW, 32'h0);

    drive_a(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd8);
    #1;
    check("pass_stall", {31'b0, bus_a.StallM}, 32'h0);
    tick();
    check("pass_aluout", bus_a.ALUOutW, 32'h0000_1234);
    check("pass_writereg", {27'b0, bus_a.WriteRegW}, 32'd8);
    check("pass_regwrite", {31'b0, bus_a.RegWriteW}, 32'h1);

    access_a("st10", 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0);
    access_a("ld10", 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd9);
    check("ld10_data", bus_a.ReadDataW, 32'hDEAD_BEEF);
    check("ld10_memtoreg", {31'b0, bus_a.MemtoRegW}, 32'h1);
    check("ld10_writereg", {27'b0, bus_a.WriteRegW}, 32'd9);
    check("ld10_regwrite", {31'b0, bus_a.RegWriteW}, 32'h1);

    access_a("st403", 1'b0, 1'b0, 1'b1, 32'h0000_0403, 32'h1111_1111, 5'd0);
    access_a("ld0", 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 5'd3);
    check("alias_data", bus_a.ReadDataW, 32'h1111_1111);

    // Reset mid-clock with a held access: everything clears before the next edge.
    drive_a(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd7);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_stall", {31'b0, bus_a.StallM}, 32'h0);
    check("rst_async_regwrite", {31'b0, bus_a.RegWriteW}, 32'h0);
    check("rst_async_aluout", bus_a.ALUOutW, 32'h0);
    check("rst_async_readdata", bus_a.ReadDataW, 32'h0);
    check("rst_async_writereg", {27'b0, bus_a.WriteRegW}, 32'h0);
    drive_a(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    rst = 1'b0;

    access_a("st20a", 1'b0, 1'b0, 1'b1, 32'h20, 32'h55AA_55AA, 5'd0);
    drive_a(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 5'd0);
    #1;
    check("rw_stall0", {31'b0, bus_a.StallM}, 32'h1);
    tick();
    check("rw_stall1", {31'b0, bus_a.StallM}, 32'h1);
    rst = 1'b1;
    #1;
    check("rw_rst_stall", {31'b0, bus_a.StallM}, 32'h0);
    drive_a(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    tick();
    rst = 1'b0;
    access_a("ld20", 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd4);
    check("rw_data", bus_a.ReadDataW, 32'h55AA_55AA);

    for (int i = 0; i < 4; i++) begin
      logic [31:0] v;
      v = 32'hA500_0000 + 32'(i * 32'h0101);
      drive_z(1'b0, 1'b0, 1'b1, 32'(i * 4 + 64), v, 5'd0);
      #1;
      check("z_st_stall", {31'b0, bus_z.StallM}, 32'h0);
      tick();
      drive_z(1'b1, 1'b1, 1'b0, 32'(i * 4 + 64), 32'h0, 5'(i + 1));
      #1;
      check("z_ld_stall", {31'b0, bus_z.StallM}, 32'h0);
      tick();
      check("z_ld_data", bus_z.ReadDataW, v);
      check("z_ld_writereg", {27'b0, bus_z.WriteRegW}, 32'(i + 1));
    end
    drive_z(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- MEM stage of the pipelined MIPS core, and the producer side of the M->W interface consumed by the write-back stage.
- Holds the word-addressed data memory and the MEM/WB pipeline register.
- Adds a parameterised wait-state controller. It stalls the upstream pipeline for multi-cycle loads and stores, and drives RegWriteW, MemtoRegW, ReadDataW, ALUOutW and WriteRegW.

Parameters:
- ADDR_BITS, 8, word-address width; memory holds 2^ADDR_BITS 32-bit words.
- MEM_LATENCY, 2, extra wait cycles per load/store (0 = single-cycle memory).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- RegWriteM  input  1  instruction in M writes the register file.
- MemtoRegM  input  1  instruction in M is a load.
- MemWriteM  input  1  instruction in M is a store.
- ALUOutM  input  32  ALU result; byte address for load/store.
- WriteDataM  input  32  store data.
- WriteRegM  input  5  destination register.
- StallM  output  1  memory busy; F/D/E/M must hold and the hazard unit must freeze.
- RegWriteW  output  1  registered, to write-back.
- MemtoRegW  output  1  registered, to write-back.
- ReadDataW  output  32  registered load data.
- ALUOutW  output  32  registered ALU result.
- WriteRegW  output  5  registered destination register.

Behaviour:
- Reset (async, immediate):
  - all W outputs 0; StallM 0.
  - FSM to IDLE; wait counter 0; any pending store discarded.
  - Memory array is not reset.
- Memory access:
  - Word index = ALUOutM[ADDR_BITS+1:2]; bits [1:0] ignored.
  - Upper address bits are ignored, so addresses wrap modulo 2^ADDR_BITS words.
- An access is MemtoRegM=1 or MemWriteM=1. If both are set, the store has priority and the load data is still captured from the pre-store contents.
- FSM states: IDLE and WAIT.
  - IDLE, no access: StallM=0. The W register captures the M inputs at each edge; ReadDataW captures mem[index] (don't-care to write-back).
  - IDLE, access, MEM_LATENCY=0: completes in the same cycle.
    - Store: mem[index] written at the edge.
    - Load: ReadDataW captures mem[index] at the edge.
    - StallM stays 0.
  - IDLE, access, MEM_LATENCY=N>0:
    - StallM=1 combinationally in the presentation cycle; counter loads N-1; at the edge, go to WAIT.
    - Upstream holds the M inputs stable while StallM=1.
  - WAIT, counter>0: StallM=1; counter decrements each edge.
  - WAIT, counter==0: StallM=0; the access completes at this edge as in the MEM_LATENCY=0 case; go to IDLE.
- Per-access timing: StallM is high for exactly N cycles; data appears on ReadDataW N+1 edges after the access is first presented.
- While StallM=1, a bubble is inserted into W at every edge:
  - RegWriteW=0, MemtoRegW=0, WriteRegW=0.
  - ALUOutW and ReadDataW hold their values.
- A store is committed exactly once, at the completing edge, never during wait cycles.
- Back-to-back store then load to the same address: the load returns the stored value.
- A new access arriving in the cycle after completion is handled normally (IDLE -> WAIT); no idle gap is required.
- Reset during WAIT: the in-flight store is not written and W clears. After reset deassertion, a re-presented access restarts a full N-cycle wait.
- Non-memory instructions never stall and pass to W with 1-cycle latency.

Test Plan:
- Reset: assert rst mid-clock with non-zero inputs -> all W outputs and StallM read 0 immediately, before the next edge.
- ALU pass-through (RegWriteM=1, ALUOutM=0x0000_1234, WriteRegM=8, MEM_LATENCY=2) -> after 1 edge: ALUOutW=0x1234, WriteRegW=8, RegWriteW=1; StallM never high.
- Store then load (MEM_LATENCY=2):
  - Store 0xDEADBEEF to address 0x10 -> StallM high exactly 2 cycles, bubbles in W.
  - Then load from 0x10, WriteRegM=9 -> ReadDataW=0xDEADBEEF, MemtoRegW=1, WriteRegW=9 on the third edge.
- Address aliasing (ADDR_BITS=8): store 0x11111111 to 0x0000_0403, then load from 0x0000_0000 -> ReadDataW=0x11111111 (index 0).
- Reset during WAIT: store 0xCAFEF00D to 0x20, assert rst during the first stall cycle; after release, load 0x20 -> the previous value of word 8 is returned, not 0xCAFEF00D.
- MEM_LATENCY=0: alternate stores and loads every cycle -> StallM constantly 0; each load returns the value of the preceding store one edge later.
